key_input_conditioner: RTL and testbench

Per-key input conditioner for the synthesizer's push buttons. It synchronises each raw, asynchronous key line to `clk` and debounces it with a per-key stability counter. It outputs a clean held level plus a single-cycle press strobe per key. The strobe of the wave-type key drives the `mode_key` input of the wave-type mode state machine directly downstream, so one physical press advances the wave type exactly once.

---
 rtl/key_input_conditioner_if.sv | 24 ++
 rtl/key_input_conditioner.sv | 65 ++++++
 tb/tb_key_input_conditioner.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/key_input_conditioner_if.sv
// Key conditioner signal bundle: raw button lines in, debounced level/strobe out.
// The conditioner takes the slave side; the surrounding logic takes the master side.
interface key_input_conditioner_if #(
  parameter int unsigned NUM_KEYS = 14
);
  logic [NUM_KEYS-1:0] keys_raw;
  logic [NUM_KEYS-1:0] keys_level;
  logic [NUM_KEYS-1:0] keys_strobe;
  logic                mode_key;

  modport master (
    output keys_raw,
    input  keys_level,
    input  keys_strobe,
    input  mode_key
  );

  modport slave (
    input  keys_raw,
    output keys_level,
    output keys_strobe,
    output mode_key
  );
endinterface

// File: rtl/key_input_conditioner.sv
// Per-key 2-flop synchroniser plus stability-counter debouncer, with a one-cycle press strobe.
// The top key's strobe doubles as mode_key for the wave-type mode FSM.
module key_input_conditioner #(
  parameter int unsigned NUM_KEYS        = 14,
  parameter int unsigned DEBOUNCE_CYCLES = 1000,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input logic                    clk,
  input logic                    n_rst,
  key_input_conditioner_if.slave kif
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NUM_KEYS-1:0] sync1_q;
  logic [NUM_KEYS-1:0] sync2_q;
  logic [NUM_KEYS-1:0] stable_q;
  logic [NUM_KEYS-1:0] stable_d;
  logic [NUM_KEYS-1:0] strobe_q;
  logic [NUM_KEYS-1:0] strobe_d;
  logic [CNT_W-1:0]    cnt_q [NUM_KEYS];
  logic [CNT_W-1:0]    cnt_d [NUM_KEYS];

  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (sync2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CntMax) begin
        // Terminal count wins over the increment, so the counter never wraps.
        stable_d[i] = sync2_q[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
    strobe_d = stable_d & ~stable_q;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      strobe_q <= '0;
      for (int i = 0; i < NUM_KEYS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q  <= kif.keys_raw;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      strobe_q <= strobe_d;
      for (int i = 0; i < NUM_KEYS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign kif.keys_level  = stable_q;
  assign kif.keys_strobe = strobe_q;
  assign kif.mode_key    = strobe_q[NUM_KEYS-1];

endmodule

// File: tb/tb_key_input_conditioner.sv
// Bench for key_input_conditioner: directed scenarios then random bouncing keys with async resets,
// all checked against a window-based debounce reference model.
module tb_key_input_conditioner;
  localparam int NK = 4;
  localparam int D  = 4;

  logic clk   = 1'b0;
  logic n_rst = 1'b1;
  always #5 clk = ~clk;

  key_input_conditioner_if #(.NUM_KEYS(NK)) kif ();

  key_input_conditioner #(
    .NUM_KEYS       (NK),
    .DEBOUNCE_CYCLES(D)
  ) u_dut (
    .clk  (clk),
    .n_rst(n_rst),
    .kif  (kif.slave)
  );

  // Reference: sync2 is raw delayed two edges; a level flips once the last D seen
  // samples all disagree with it.
  logic [NK-1:0] m_dly0, m_dly1, m_level, m_strobe;
  logic [NK-1:0] m_hist[$];

  int n_tests = 0;
  int n_fail  = 0;
  int obs_strobe[NK];
  int mode_adv;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_dly0   = '0;
    m_dly1   = '0;
    m_level  = '0;
    m_strobe = '0;
    m_hist.delete();
  endtask

  task automatic model_edge(input logic [NK-1:0] raw);
    logic [NK-1:0] seen;
    logic [NK-1:0] nxt;
    bit            all_diff;
    if (!n_rst) begin
      model_reset();
      return;
    end
    seen   = m_dly1;
    m_dly1 = m_dly0;
    m_dly0 = raw;
    m_hist.push_back(seen);
    if (m_hist.size() > D) void'(m_hist.pop_front());
    nxt = m_level;
    for (int k = 0; k < NK; k++) begin
      if (m_hist.size() == D) begin
        all_diff = 1'b1;
        foreach (m_hist[j]) if (m_hist[j][k] == m_level[k]) all_diff = 1'b0;
        if (all_diff) nxt[k] = ~m_level[k];
      end
    end
    m_strobe = nxt & ~m_level;
    m_level  = nxt;
  endtask

  task automatic clr_counts();
    for (int k = 0; k < NK; k++) obs_strobe[k] = 0;
    mode_adv = 0;
  endtask

  task automatic tick(input logic [NK-1:0] raw);
    kif.keys_raw = raw;
    @(posedge clk);
    model_edge(raw);
    #1;
    chk("model_level", 32'(kif.keys_level), 32'(m_level));
    chk("model_strobe", 32'(kif.keys_strobe), 32'(m_strobe));
    chk("model_mode", 32'(kif.mode_key), 32'(m_strobe[NK-1]));
    for (int k = 0; k < NK; k++) if (kif.keys_strobe[k] === 1'b1) obs_strobe[k]++;
    if (kif.mode_key === 1'b1) mode_adv++;
  endtask

  task automatic async_reset_check();
    #2 n_rst = 1'b0;
    #1;
    model_reset();
    chk("rst_level", 32'(kif.keys_level), 32'h0);
    chk("rst_strobe", 32'(kif.keys_strobe), 32'h0);
    chk("rst_mode", 32'(kif.mode_key), 32'h0);
  endtask

  initial begin
    logic [NK-1:0] raw;
    int            rem[NK];

    kif.keys_raw = '0;
    model_reset();
    clr_counts();

    // 1: reset between edges clears outputs at once, and holds them through pressed keys.
    #3 n_rst = 1'b0;
    #1;
    chk("rst0_level", 32'(kif.keys_level), 32'h0);
    chk("rst0_strobe", 32'(kif.keys_strobe), 32'h0);
    chk("rst0_mode", 32'(kif.mode_key), 32'h0);
    repeat (3) tick(4'b1111);
    chk("rst_hold_level", 32'(kif.keys_level), 32'h0);
    n_rst = 1'b1;
    repeat (4) tick(4'b0000);

    // 2: clean press on key 0.
    clr_counts();
    for (int e = 0; e <= 6; e++) begin
      tick(4'b0001);
      if (e == 4) chk("press_e4_level", 32'(kif.keys_level[0]), 32'h0);
      if (e == 5) begin
        chk("press_e5_level", 32'(kif.keys_level[0]), 32'h1);
        chk("press_e5_strobe", 32'(kif.keys_strobe[0]), 32'h1);
      end
      if (e == 6) chk("press_e6_strobe", 32'(kif.keys_strobe[0]), 32'h0);
    end
    repeat (50) tick(4'b0001);
    chk("hold_one_strobe", 32'(obs_strobe[0]), 32'h1);
    chk("hold_level", 32'(kif.keys_level[0]), 32'h1);

    // 3: bounce rejection on key 1.
    clr_counts();
    repeat (5) begin
      repeat (3) tick(4'b0011);
      tick(4'b0001);
    end
    chk("bounce_no_strobe", 32'(obs_strobe[1]), 32'h0);
    for (int e = 0; e <= 5; e++) begin
      tick(4'b0011);
      if (e == 4) chk("bounce_e4_strobe", 32'(kif.keys_strobe[1]), 32'h0);
      if (e == 5) chk("bounce_e5_strobe", 32'(kif.keys_strobe[1]), 32'h1);
    end
    repeat (10) tick(4'b0011);
    chk("bounce_one_strobe", 32'(obs_strobe[1]), 32'h1);

    // 4: short release ignored, long release accepted without strobe, repress strobes once.
    clr_counts();
    repeat (10) tick(4'b0111);
    chk("rel_first_press", 32'(obs_strobe[2]), 32'h1);
    repeat (2) tick(4'b0011);
    repeat (8) tick(4'b0111);
    chk("rel_short_level", 32'(kif.keys_level[2]), 32'h1);
    chk("rel_short_strobe", 32'(obs_strobe[2]), 32'h1);
    for (int e = 0; e < 8; e++) begin
      tick(4'b0011);
      if (e == 4) chk("rel_e4_level", 32'(kif.keys_level[2]), 32'h1);
      if (e == 5) chk("rel_e5_level", 32'(kif.keys_level[2]), 32'h0);
    end
    chk("rel_no_strobe", 32'(obs_strobe[2]), 32'h1);
    repeat (12) tick(4'b0111);
    chk("repress_strobe", 32'(obs_strobe[2]), 32'h2);
    repeat (12) tick(4'b0000);

    // 5: mode key and key 0 pressed together.
    clr_counts();
    for (int e = 0; e <= 5; e++) begin
      tick(4'b1001);
      if (e == 5) begin
        chk("simul_strobe", 32'(kif.keys_strobe), 32'h9);
        chk("simul_mode", 32'(kif.mode_key), 32'h1);
      end
    end
    repeat (20) tick(4'b1001);
    chk("mode_one_advance", 32'(mode_adv), 32'h1);
    chk("simul_k0_once", 32'(obs_strobe[0]), 32'h1);
    repeat (12) tick(4'b0000);

    // 6: reset mid-debounce restarts the count.
    clr_counts();
    repeat (3) tick(4'b0001);
    async_reset_check();
    tick(4'b0001);
    n_rst = 1'b1;
    for (int e = 0; e <= 5; e++) begin
      tick(4'b0001);
      if (e == 4) chk("rstmid_e4_strobe", 32'(kif.keys_strobe[0]), 32'h0);
      if (e == 5) chk("rstmid_e5_strobe", 32'(kif.keys_strobe[0]), 32'h1);
    end
    repeat (6) tick(4'b0000);

    // Random bouncing on all keys with occasional asynchronous resets.
    raw = '0;
    for (int k = 0; k < NK; k++) rem[k] = $urandom_range(1, 9);
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < NK; k++) begin
        rem[k]--;
        if (rem[k] <= 0) begin
          raw[k] = ~raw[k];
          rem[k] = $urandom_range(1, 9);
        end
      end
      if ($urandom_range(0, 299) == 0) begin
        async_reset_check();
        repeat ($urandom_range(1, 2)) tick(raw);
        n_rst = 1'b1;
      end
      tick(raw);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
